mem_port_arbiter: RTL and testbench

- Sits directly upstream of the unified 32-bit word RAM.
- Arbitrates two requesters onto the RAM's single combinational-read / synchronous-write port:
  - instruction fetch (IF, read only);
  - load/store unit (LS, read/write).
- Each port has a valid/ready request channel and a one-entry registered response channel.
- Addresses beyond the populated depth are flagged as errors and never written.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_rsp_slot.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types and constants for the unified-RAM port arbiter.
//            - ADDR_W / DATA_W : default address and word widths
//            - port_e          : identifies the instruction-fetch or
//                                load/store requester
//            - mem_rsp_t       : contents of one registered response slot
// Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_e;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] data;
  } mem_rsp_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_rsp_slot.sv
`default_nettype none
// ============================================================================
// Module   : mem_rsp_slot
// Purpose  : One-entry registered response holder for a single requester.
//            Also reports whether that requester may be granted this cycle.
// Ports    : i_clk, i_rst_n     clock / asynchronous active-low reset
//            i_req_valid        requester has a request pending
//            i_rsp_ready        consumer takes the held response
//            i_load             request granted: capture a response this edge
//            i_load_err         captured response is an out-of-range error
//            i_load_data        captured response data
//            o_eligible         request may be granted this cycle
//            o_rsp              held response (valid / err / data)
// Revision : 1.0  initial release
// ============================================================================
module mem_rsp_slot
  import mem_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  input  logic              i_rsp_ready,
  input  logic              i_load,
  input  logic              i_load_err,
  input  logic [DATA_W-1:0] i_load_data,
  output logic              o_eligible,
  output mem_rsp_t          o_rsp
);

  mem_rsp_t rsp_q;
  mem_rsp_t rsp_d;

  // Eligible when the slot is free now, or will be freed on this edge by the
  // consumer, so a drain and a refill can share one cycle.
  assign o_eligible = i_req_valid && (!rsp_q.valid || i_rsp_ready);

  always_comb begin
    rsp_d = rsp_q;
    if (i_load) begin
      rsp_d.valid = 1'b1;
      rsp_d.err   = i_load_err;
      rsp_d.data  = i_load_data;
    end else if (rsp_q.valid && i_rsp_ready) begin
      rsp_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  assign o_rsp = rsp_q;

endmodule : mem_rsp_slot
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin arbiter placing instruction-fetch (read only) and
//            load/store (read/write) requests onto the single port of a
//            unified word RAM with combinational read and synchronous write.
//            Each requester gets a one-entry registered response, one cycle
//            after its grant. Addresses >= DEPTH answer with err=1 and are
//            never written.
// Ports    : i_clk / i_rst_n                      clock, async active-low reset
//            i_if_req_valid/o_if_req_ready/i_if_addr          fetch request
//            o_if_rsp_valid/i_if_rsp_ready/o_if_rsp_data/err  fetch response
//            i_ls_req_valid/o_ls_req_ready/i_ls_we/i_ls_addr/i_ls_wdata
//                                                 load/store request
//            o_ls_rsp_valid/i_ls_rsp_ready/o_ls_rsp_data/err  l/s response
//            o_ram_set/o_ram_addr/o_ram_data/i_ram_data       RAM port
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int DEPTH  = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req_valid,
  output logic              o_if_req_ready,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_rsp_valid,
  input  logic              i_if_rsp_ready,
  output logic [DATA_W-1:0] o_if_rsp_data,
  output logic              o_if_rsp_err,
  input  logic              i_ls_req_valid,
  output logic              o_ls_req_ready,
  input  logic              i_ls_we,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  output logic              o_ls_rsp_valid,
  input  logic              i_ls_rsp_ready,
  output logic [DATA_W-1:0] o_ls_rsp_data,
  output logic              o_ls_rsp_err,
  output logic              o_ram_set,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data,
  input  logic [DATA_W-1:0] i_ram_data
);

  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  port_e             last_grant_q;
  port_e             last_grant_d;
  logic              grant_if;
  logic              grant_ls;
  logic              if_elig;
  logic              ls_elig;
  logic [ADDR_W-1:0] ram_addr;
  logic              addr_err;
  logic [DATA_W-1:0] if_load_data;
  logic [DATA_W-1:0] ls_load_data;
  mem_rsp_t          if_rsp;
  mem_rsp_t          ls_rsp;

  // --------------------------------------------------------------------------
  // Last-grant state: register / next-state / grant outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant_q <= PORT_LS;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_if) begin
      last_grant_d = PORT_IF;
    end else if (grant_ls) begin
      last_grant_d = PORT_LS;
    end
  end

  // Grants are suppressed while reset is asserted so the RAM sees no write
  // on a clock edge that falls inside a reset pulse.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (i_rst_n) begin
      if (if_elig && (!ls_elig || (last_grant_q == PORT_LS))) begin
        grant_if = 1'b1;
      end else if (ls_elig) begin
        grant_ls = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // RAM drive and response data selection
  // --------------------------------------------------------------------------
  always_comb begin
    ram_addr = '0;
    if (grant_if) begin
      ram_addr = i_if_addr;
    end else if (grant_ls) begin
      ram_addr = i_ls_addr;
    end
  end

  assign addr_err     = ({1'b0, ram_addr} >= c_depth);
  assign o_ram_addr   = ram_addr;
  assign o_ram_data   = grant_ls ? i_ls_wdata : '0;
  assign o_ram_set    = grant_ls && i_ls_we && !addr_err;
  assign if_load_data = addr_err ? '0 : i_ram_data;
  assign ls_load_data = (addr_err || i_ls_we) ? '0 : i_ram_data;

  // --------------------------------------------------------------------------
  // Response slots
  // --------------------------------------------------------------------------
  mem_rsp_slot u_if_slot (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_if_req_valid),
    .i_rsp_ready (i_if_rsp_ready),
    .i_load      (grant_if),
    .i_load_err  (addr_err),
    .i_load_data (if_load_data),
    .o_eligible  (if_elig),
    .o_rsp       (if_rsp)
  );

  mem_rsp_slot u_ls_slot (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_ls_req_valid),
    .i_rsp_ready (i_ls_rsp_ready),
    .i_load      (grant_ls),
    .i_load_err  (addr_err),
    .i_load_data (ls_load_data),
    .o_eligible  (ls_elig),
    .o_rsp       (ls_rsp)
  );

  assign o_if_req_ready = grant_if;
  assign o_ls_req_ready = grant_ls;
  assign o_if_rsp_valid = if_rsp.valid;
  assign o_if_rsp_err   = if_rsp.err;
  assign o_if_rsp_data  = if_rsp.data;
  assign o_ls_rsp_valid = ls_rsp.valid;
  assign o_ls_rsp_err   = ls_rsp.err;
  assign o_ls_rsp_data  = ls_rsp.data;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter with a behavioural
//            256-word RAM, a vector table of per-cycle requests with expected
//            grants, and per-port response scoreboards.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_init = 1'b1;
  logic        if_req_valid = 1'b0, if_rsp_ready = 1'b0;
  logic [15:0] if_addr = '0;
  logic        ls_req_valid = 1'b0, ls_rsp_ready = 1'b0, ls_we = 1'b0;
  logic [15:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        if_req_ready, if_rsp_valid, if_rsp_err;
  logic [31:0] if_rsp_data;
  logic        ls_req_ready, ls_rsp_valid, ls_rsp_err;
  logic [31:0] ls_rsp_data;
  logic        ram_set;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .DEPTH(256)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req_valid(if_req_valid), .o_if_req_ready(if_req_ready), .i_if_addr(if_addr),
    .o_if_rsp_valid(if_rsp_valid), .i_if_rsp_ready(if_rsp_ready),
    .o_if_rsp_data(if_rsp_data), .o_if_rsp_err(if_rsp_err),
    .i_ls_req_valid(ls_req_valid), .o_ls_req_ready(ls_req_ready), .i_ls_we(ls_we),
    .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
    .o_ls_rsp_valid(ls_rsp_valid), .i_ls_rsp_ready(ls_rsp_ready),
    .o_ls_rsp_data(ls_rsp_data), .o_ls_rsp_err(ls_rsp_err),
    .o_ram_set(ram_set), .o_ram_addr(ram_addr), .o_ram_data(ram_wdata),
    .i_ram_data(ram_rdata)
  );

  // Behavioural RAM: combinational read, write on rising edge.
  function automatic logic [31:0] init_val(input int i);
    return (i == 5) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(i));
  endfunction

  logic [31:0] ram [0:255];
  assign ram_rdata = (ram_addr < 16'd256) ? ram[ram_addr[7:0]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (ram_set && ram_addr < 16'd256) begin
      ram[ram_addr[7:0]] <= ram_wdata;
    end
  end

  // Bench-side view of the RAM contents, updated only from the vector table.
  logic [31:0] shadow [0:255];

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t if_q[$];
  exp_t ls_q[$];

  typedef struct {
    logic        ifv;
    logic [15:0] ifa;
    logic        ifrr;
    logic        lsv;
    logic        we;
    logic [15:0] lsa;
    logic [31:0] wd;
    logic        lsrr;
    logic        e_ifr;
    logic        e_lsr;
    logic        e_set;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic we);
    exp_t e;
    e.err  = (a >= 16'd256);
    e.data = (e.err || we) ? 32'h0 : shadow[a[7:0]];
    return e;
  endfunction

  // Consume side of the scoreboard: valid must match queue occupancy, and a
  // handed-off response must match the oldest expectation.
  task automatic sb_step();
    exp_t e;
    chk("if_rsp_valid", 32'(if_rsp_valid), 32'(if_q.size() != 0));
    if (if_rsp_valid && if_rsp_ready) begin
      if (if_q.size() == 0) begin
        total++; bad++;
        $display("FAIL if_rsp_unexpected: got response with empty scoreboard at %0t", $time);
      end else begin
        e = if_q.pop_front();
        chk("if_rsp_data", if_rsp_data, e.data);
        chk("if_rsp_err", 32'(if_rsp_err), 32'(e.err));
      end
    end
    chk("ls_rsp_valid", 32'(ls_rsp_valid), 32'(ls_q.size() != 0));
    if (ls_rsp_valid && ls_rsp_ready) begin
      if (ls_q.size() == 0) begin
        total++; bad++;
        $display("FAIL ls_rsp_unexpected: got response with empty scoreboard at %0t", $time);
      end else begin
        e = ls_q.pop_front();
        chk("ls_rsp_data", ls_rsp_data, e.data);
        chk("ls_rsp_err", 32'(ls_rsp_err), 32'(e.err));
      end
    end
  endtask

  initial begin
    vec_t        v;
    exp_t        e;
    logic [15:0] ea;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);

    //                ifv ifa     ifr lsv we lsa     wd            lsr eIF eLS eSet
    vecs.push_back('{1, 16'h0005, 1, 0, 0, 16'h0000, 32'h0,        1, 1, 0, 0});
    vecs.push_back('{0, 16'h0000, 1, 1, 1, 16'h0010, 32'h12345678, 1, 0, 1, 1});
    vecs.push_back('{0, 16'h0000, 1, 1, 0, 16'h0010, 32'h0,        1, 0, 1, 0});
    vecs.push_back('{1, 16'h0007, 1, 1, 0, 16'h0008, 32'h0,        1, 1, 0, 0});
    vecs.push_back('{1, 16'h0009, 1, 1, 0, 16'h0008, 32'h0,        1, 0, 1, 0});
    vecs.push_back('{1, 16'h0009, 1, 1, 0, 16'h0020, 32'h0,        1, 1, 0, 0});
    vecs.push_back('{1, 16'h000B, 1, 1, 0, 16'h0020, 32'h0,        1, 0, 1, 0});
    vecs.push_back('{1, 16'h000B, 0, 1, 1, 16'h0030, 32'hCAFEF00D, 1, 1, 0, 0});
    vecs.push_back('{1, 16'h000C, 0, 1, 1, 16'h0030, 32'hCAFEF00D, 1, 0, 1, 1});
    vecs.push_back('{1, 16'h000C, 0, 1, 0, 16'h0030, 32'h0,        1, 0, 1, 0});
    vecs.push_back('{1, 16'h000C, 1, 1, 0, 16'h0031, 32'h0,        1, 1, 0, 0});
    vecs.push_back('{0, 16'h0000, 1, 1, 0, 16'h0031, 32'h0,        1, 0, 1, 0});
    vecs.push_back('{0, 16'h0000, 1, 1, 1, 16'h0100, 32'h55555555, 1, 0, 1, 0});
    vecs.push_back('{1, 16'hFFFF, 1, 0, 0, 16'h0000, 32'h0,        1, 1, 0, 0});
    vecs.push_back('{0, 16'h0000, 1, 1, 0, 16'h00FF, 32'h0,        1, 0, 1, 0});
    vecs.push_back('{0, 16'h0000, 1, 0, 0, 16'h0000, 32'h0,        1, 0, 0, 0});

    // ---------------- reset state ----------------
    @(negedge clk); @(negedge clk); #1;
    chk("rst_if_rsp_valid", 32'(if_rsp_valid), 0);
    chk("rst_if_rsp_data", if_rsp_data, 0);
    chk("rst_if_rsp_err", 32'(if_rsp_err), 0);
    chk("rst_ls_rsp_valid", 32'(ls_rsp_valid), 0);
    chk("rst_ls_rsp_data", ls_rsp_data, 0);
    chk("rst_ls_rsp_err", 32'(ls_rsp_err), 0);
    rst_n = 1'b1;
    ram_init = 1'b0;

    // ---------------- table-driven cycles ----------------
    foreach (vecs[k]) begin
      v = vecs[k];
      @(negedge clk);
      if_req_valid = v.ifv; if_addr = v.ifa; if_rsp_ready = v.ifrr;
      ls_req_valid = v.lsv; ls_we = v.we; ls_addr = v.lsa; ls_wdata = v.wd;
      ls_rsp_ready = v.lsrr;
      #1;
      chk($sformatf("v%0d_if_req_ready", k), 32'(if_req_ready), 32'(v.e_ifr));
      chk($sformatf("v%0d_ls_req_ready", k), 32'(ls_req_ready), 32'(v.e_lsr));
      chk($sformatf("v%0d_ram_set", k), 32'(ram_set), 32'(v.e_set));
      ea = v.e_ifr ? v.ifa : (v.e_lsr ? v.lsa : 16'h0);
      chk($sformatf("v%0d_ram_addr", k), 32'(ram_addr), 32'(ea));
      chk($sformatf("v%0d_ram_data", k), ram_wdata, v.e_lsr ? v.wd : 32'h0);
      sb_step();
      if (v.e_ifr) if_q.push_back(model(v.ifa, 1'b0));
      if (v.e_lsr) begin
        e = model(v.lsa, v.we);
        ls_q.push_back(e);
        if (v.we && !e.err) shadow[v.lsa[7:0]] = v.wd;
      end
    end
    chk("drain_if_q", 32'(if_q.size()), 0);
    chk("drain_ls_q", 32'(ls_q.size()), 0);

    // ---------------- fill both slots, then async reset ----------------
    @(negedge clk);
    if_req_valid = 1; if_addr = 16'h0003; if_rsp_ready = 0;
    ls_req_valid = 1; ls_we = 0; ls_addr = 16'h0004; ls_rsp_ready = 0;
    #1 chk("fill_if_ready", 32'(if_req_ready), 1);
    chk("fill_ls_ready_blocked", 32'(ls_req_ready), 0);
    @(negedge clk); #1;
    chk("fill_ls_ready", 32'(ls_req_ready), 1);
    chk("fill_if_ready_blocked", 32'(if_req_ready), 0);
    @(negedge clk);
    if_req_valid = 0; ls_req_valid = 0;
    #1 chk("fill_if_valid", 32'(if_rsp_valid), 1);
    chk("fill_if_data", if_rsp_data, shadow[3]);
    chk("fill_ls_valid", 32'(ls_rsp_valid), 1);
    chk("fill_ls_data", ls_rsp_data, shadow[4]);
    #1;
    if_req_valid = 1; if_addr = 16'h0005;
    ls_req_valid = 1; ls_we = 1; ls_addr = 16'h0040; ls_wdata = 32'h77777777;
    rst_n = 1'b0;
    #1 chk("arst_if_valid", 32'(if_rsp_valid), 0);
    chk("arst_ls_valid", 32'(ls_rsp_valid), 0);
    chk("arst_ram_set", 32'(ram_set), 0);
    chk("arst_ls_ready", 32'(ls_req_ready), 0);
    @(posedge clk); #1;
    chk("arst_no_write", ram[8'h40], shadow[8'h40]);
    @(negedge clk);
    rst_n = 1'b1; if_rsp_ready = 1; ls_rsp_ready = 1;
    #1 chk("post_rst_if_priority", 32'(if_req_ready), 1);
    chk("post_rst_ls_wait", 32'(ls_req_ready), 0);
    chk("post_rst_addr", 32'(ram_addr), 32'h5);
    @(negedge clk);
    if_addr = 16'h0006;
    #1 chk("post_rst_ls_turn", 32'(ls_req_ready), 1);
    chk("post_rst_if_wait", 32'(if_req_ready), 0);
    chk("post_rst_ram_set", 32'(ram_set), 1);
    chk("post_rst_if_data", if_rsp_data, 32'hDEADBEEF);
    @(negedge clk);
    if_req_valid = 0; ls_req_valid = 0;
    #1 chk("post_rst_ls_valid", 32'(ls_rsp_valid), 1);
    chk("post_rst_ls_data", ls_rsp_data, 0);
    chk("post_rst_write", ram[8'h40], 32'h77777777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
